// File: rtl/key_event_gen_pkg.sv
// -----------------------------------------------------------------------------
// key_event_gen_pkg
// Shared definitions for the per-button key event generator and the keypad
// decoder that consumes its events.
//   - key_state_e    : button FSM states (IDLE / SHORT / REPEAT)
//   - DEF_LONG_CYC   : default long-press threshold (1 s at 50 MHz)
//   - DEF_REPEAT_CYC : default auto-repeat period (200 ms at 50 MHz)
//   - DEF_CNT_W      : default counter width covering both thresholds
//   - cnt_fits()     : true when a value is representable in a given width
// -----------------------------------------------------------------------------
package key_event_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHORT  = 2'd1,
        ST_REPEAT = 2'd2
    } key_state_e;

    localparam int DEF_LONG_CYC   = 50_000_000;
    localparam int DEF_REPEAT_CYC = 10_000_000;
    localparam int DEF_CNT_W      = 26;

    // A counter of 'width' bits can hold 'value' (widths of 32+ always can).
    function automatic bit cnt_fits(input int unsigned value, input int width);
        if (width >= 32) begin
            return 1'b1;
        end else begin
            return (value < (32'd1 << width));
        end
    endfunction

endpackage

// File: rtl/key_event_gen_if.sv
// -----------------------------------------------------------------------------
// key_event_gen_if
// Bundles the debounced button level and the key event outputs of one button.
//   btn_i        : debounced level, 0 = pressed, 1 = idle
//   press_o      : one-cycle pulse on press
//   click_o      : one-cycle pulse on release before the long threshold
//   long_press_o : one-cycle pulse when the hold reaches the long threshold
//   repeat_o     : one-cycle pulse every repeat period after a long press
//   release_o    : one-cycle pulse on any release
//   held_o       : level, 1 while the button is considered held
// Modports:
//   master : the event generator (consumes btn_i, drives the events)
//   slave  : the surrounding logic (drives btn_i, consumes the events)
// -----------------------------------------------------------------------------
interface key_event_gen_if;

    logic btn_i;
    logic press_o;
    logic click_o;
    logic long_press_o;
    logic repeat_o;
    logic release_o;
    logic held_o;

    modport master (
        input  btn_i,
        output press_o,
        output click_o,
        output long_press_o,
        output repeat_o,
        output release_o,
        output held_o
    );

    modport slave (
        output btn_i,
        input  press_o,
        input  click_o,
        input  long_press_o,
        input  repeat_o,
        input  release_o,
        input  held_o
    );

endinterface

// File: rtl/key_event_gen.sv
// -----------------------------------------------------------------------------
// key_event_gen
// Turns a debounced active-low button level into single-cycle key events
// (press, click, long press, auto-repeat, release) plus a registered held level.
// One FSM and one counter shared by the long-press and auto-repeat phases.
// Every output is a flop; btn_i only feeds next-state logic.
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   kif : key_event_gen_if.master (btn_i in, event outputs out)
// -----------------------------------------------------------------------------
module key_event_gen
    import key_event_gen_pkg::*;
#(
    parameter int LONG_CYC   = DEF_LONG_CYC,
    parameter int REPEAT_CYC = DEF_REPEAT_CYC,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    key_event_gen_if.master         kif
);

    // Elaboration-time parameter sanity.
    if (LONG_CYC < 2) begin : g_chk_long
        $error("key_event_gen: LONG_CYC must be >= 2");
    end
    if (REPEAT_CYC < 2) begin : g_chk_rep
        $error("key_event_gen: REPEAT_CYC must be >= 2");
    end
    if (!cnt_fits(LONG_CYC - 1, CNT_W) || !cnt_fits(REPEAT_CYC - 1, CNT_W)) begin : g_chk_w
        $error("key_event_gen: CNT_W too small for LONG_CYC/REPEAT_CYC");
    end

    // Terminal counts: the counter is zeroed on state entry, so the threshold
    // edge is the one where it has already reached N-1.
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYC - 1);

    key_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             click_q, click_d;
    logic             long_q, long_d;
    logic             rep_q, rep_d;
    logic             rel_q, rel_d;
    logic             held_q, held_d;

    // Next-state, counter and event decode; release wins over a threshold.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        click_d = 1'b0;
        long_d  = 1'b0;
        rep_d   = 1'b0;
        rel_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!kif.btn_i) begin
                    press_d = 1'b1;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ST_SHORT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHORT: begin
                if (kif.btn_i) begin
                    click_d = 1'b1;
                    rel_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (cnt_q == LONG_LAST) begin
                    long_d  = 1'b1;
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ST_REPEAT;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            ST_REPEAT: begin
                if (kif.btn_i) begin
                    rel_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (cnt_q == REPEAT_LAST) begin
                    rep_d   = 1'b1;
                    cnt_d   = {CNT_W{1'b0}};
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                // Unreachable encoding: recover to a quiet idle.
                state_d = ST_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
        held_d = (state_d != ST_IDLE);
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            press_q <= 1'b0;
            click_q <= 1'b0;
            long_q  <= 1'b0;
            rep_q   <= 1'b0;
            rel_q   <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
            click_q <= click_d;
            long_q  <= long_d;
            rep_q   <= rep_d;
            rel_q   <= rel_d;
            held_q  <= held_d;
        end
    end

    assign kif.press_o      = press_q;
    assign kif.click_o      = click_q;
    assign kif.long_press_o = long_q;
    assign kif.repeat_o     = rep_q;
    assign kif.release_o    = rel_q;
    assign kif.held_o       = held_q;

endmodule

// File: tb/tb_key_event_gen.sv
// -----------------------------------------------------------------------------
// tb_key_event_gen
// Directed stimulus for key_event_gen with LONG_CYC=8, REPEAT_CYC=4, CNT_W=4.
// A reference model that reasons in "edges since the press was detected"
// predicts every output each cycle; literal checks pin event positions.
// -----------------------------------------------------------------------------
module tb_key_event_gen;

    localparam int LONG   = 8;
    localparam int REPEAT = 4;
    localparam int CW     = 4;

    logic clk;
    logic rst;

    key_event_gen_if kif ();

    key_event_gen #(
        .LONG_CYC   (LONG),
        .REPEAT_CYC (REPEAT),
        .CNT_W      (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kif (kif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model state (updated each rising edge from sampled inputs).
    int   edge_cnt   = 0;
    bit   m_pressed  = 1'b0;
    int   m_n        = 0;   // edges elapsed since the press edge
    logic [5:0] exp_v = 6'b0; // {press, click, long, repeat, release, held}

    initial begin
        forever begin
            @(posedge clk);
            edge_cnt++;
            exp_v = 6'b0;
            if (rst) begin
                m_pressed = 1'b0;
                m_n       = 0;
            end else if (!m_pressed) begin
                if (!kif.btn_i) begin
                    exp_v[5]  = 1'b1;
                    m_pressed = 1'b1;
                    m_n       = 0;
                end
            end else begin
                m_n++;
                if (kif.btn_i) begin
                    exp_v[1]  = 1'b1;
                    exp_v[4]  = (m_n <= LONG);
                    m_pressed = 1'b0;
                end else if (m_n == LONG) begin
                    exp_v[3] = 1'b1;
                end else if (m_n > LONG && ((m_n - LONG) % REPEAT) == 0) begin
                    exp_v[2] = 1'b1;
                end
            end
            exp_v[0] = m_pressed;
        end
    end

    // Event logs used by the literal checks.
    int n_press = 0, n_click = 0, n_long = 0, n_rep = 0, n_rel = 0;
    int e_press = -1, e_click = -1, e_long = -1, e_rep = -1, e_rel = -1;
    bit cmp_en = 1'b0;

    // Per-cycle compare against the model, on the falling edge.
    initial begin
        logic [5:0] dut_v;
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                dut_v = {kif.press_o, kif.click_o, kif.long_press_o,
                         kif.repeat_o, kif.release_o, kif.held_o};
                chk($sformatf("outputs@edge%0d {press,click,long,rep,rel,held}", edge_cnt),
                    int'(dut_v), int'(exp_v));
                if (kif.press_o)      begin n_press++; e_press = edge_cnt; end
                if (kif.click_o)      begin n_click++; e_click = edge_cnt; end
                if (kif.long_press_o) begin n_long++;  e_long  = edge_cnt; end
                if (kif.repeat_o)     begin n_rep++;   e_rep   = edge_cnt; end
                if (kif.release_o)    begin n_rel++;   e_rel   = edge_cnt; end
            end
        end
    end

    // Hold btn at b for n edges; called and returning on a falling edge.
    task automatic drive(input logic b, input int n);
        for (int i = 0; i < n; i++) begin
            kif.btn_i = b;
            @(negedge clk);
        end
    endtask

    int e0, p0, c0, l0, r0, rl0;

    task automatic snap();
        e0 = edge_cnt + 1;
        p0 = n_press; c0 = n_click; l0 = n_long; r0 = n_rep; rl0 = n_rel;
    endtask

    initial begin
        rst       = 1'b1;
        kif.btn_i = 1'b0;
        @(negedge clk);
        cmp_en = 1'b1;

        // Reset held with the button down: everything stays quiet.
        drive(1'b0, 3);
        chk("rst_held", int'(kif.held_o), 0);
        chk("rst_press", int'(kif.press_o), 0);
        rst = 1'b0;
        snap();
        drive(1'b0, 1);
        chk("post_rst_press", int'(kif.press_o), 1);
        chk("post_rst_held", int'(kif.held_o), 1);
        drive(1'b0, 1);
        drive(1'b1, 3);
        chk("post_rst_click_edge", e_click - e0, 2);

        // Short press: low on edges 0-2, high at 3.
        snap();
        drive(1'b0, 3);
        drive(1'b1, 3);
        chk("short_press_edge", e_press - e0, 0);
        chk("short_click_edge", e_click - e0, 3);
        chk("short_release_edge", e_rel - e0, 3);
        chk("short_no_long", n_long - l0, 0);

        // Long hold: low on edges 0-17, high at 18.
        snap();
        drive(1'b0, 18);
        drive(1'b1, 3);
        chk("long_edge", e_long - e0, 8);
        chk("long_repeat_count", n_rep - r0, 2);
        chk("long_last_repeat_edge", e_rep - e0, 16);
        chk("long_release_edge", e_rel - e0, 18);
        chk("long_no_click", n_click - c0, 0);

        // Release exactly at the long threshold edge.
        snap();
        drive(1'b0, 8);
        drive(1'b1, 3);
        chk("edge8_click_edge", e_click - e0, 8);
        chk("edge8_no_long", n_long - l0, 0);

        // Reset in REPEAT between repeats (long@8, repeat@12, rst at 14).
        snap();
        drive(1'b0, 14);
        rst = 1'b1;
        drive(1'b0, 1);
        chk("mid_rst_held", int'(kif.held_o), 0);
        chk("mid_rst_repeat", int'(kif.repeat_o), 0);
        rst = 1'b0;
        drive(1'b1, 3);
        chk("mid_rst_no_release", n_rel - rl0, 0);
        chk("mid_rst_repeat_count", n_rep - r0, 1);
        snap();
        drive(1'b0, 1);
        chk("mid_rst_fresh_press", int'(kif.press_o), 1);
        drive(1'b1, 3);

        // Release at edge 3, pressed again at edge 4: counter restarts.
        snap();
        drive(1'b0, 3);
        drive(1'b1, 1);
        drive(1'b0, 13);
        drive(1'b1, 3);
        chk("restart_press_count", n_press - p0, 2);
        chk("restart_click_edge", e_click - e0, 3);
        chk("restart_long_edge", e_long - e0, 12);
        chk("restart_release_count", n_rel - rl0, 2);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
